multicyc_muldiv_unit: RTL

MULTICYC_MULDIV_UNIT -- requirements
Module: multicyc_muldiv_unit

---
 rtl/multicyc_muldiv_unit_pkg.sv | 22 ++
 rtl/multicyc_muldiv_unit_step.sv | 36 +++
 rtl/multicyc_muldiv_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/multicyc_muldiv_unit_pkg.sv
// Shared ISA defines for the multiply/divide unit: op codes, FSM state codes
// and small op-decode helpers.
package multicyc_muldiv_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/multicyc_muldiv_unit_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring shift-subtract divide over the {rem, q} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] qNext
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, rem} + (q[0] ? {1'b0, opnd} : '0);
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    remNext = sum[WIDTH:1];
    qNext   = {sum[0], q[WIDTH-1:1]};
    if (isDiv) begin
      // remainder stays below the divisor, so the restored value fits WIDTH bits
      if (shifted >= {1'b0, opnd}) begin
        remNext = diff[WIDTH-1:0];
        qNext   = {q[WIDTH-2:0], 1'b1};
      end else begin
        remNext = shifted[WIDTH-1:0];
        qNext   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multicyc_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO
// writes and cancel. States: IDLE wait/MT writes | CALC WIDTH steps | FIX sign fix + writeback.
module multicyc_muldiv_unit
  import multicyc_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCancel,
  input  logic             iMthi,
  input  logic             iMtlo,
  input  logic [WIDTH-1:0] iWrData,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [1:0]         opReg;
  logic               negA;
  logic               negB;
  logic               divZero;
  logic [WIDTH-1:0]   origA;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   qNext;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   hiRes;
  logic [WIDTH-1:0]   loRes;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv  (isDivOp(opReg)),
    .rem    (rem),
    .q      (q),
    .opnd   (opnd),
    .remNext(remNext),
    .qNext  (qNext)
  );

  always_comb begin
    magA = (isSignedOp(iOp) && iA[WIDTH-1]) ? -iA : iA;
    magB = (isSignedOp(iOp) && iB[WIDTH-1]) ? -iB : iB;
  end

  // most-negative / -1 needs no special case: negating 2^(WIDTH-1) wraps back to itself
  always_comb begin
    prod = {rem, q};
    if (isSignedOp(opReg) && (negA ^ negB)) prod = -prod;
    hiRes = prod[2*WIDTH-1:WIDTH];
    loRes = prod[WIDTH-1:0];
    if (isDivOp(opReg)) begin
      if (divZero) begin
        hiRes = origA;
        loRes = '1;
      end else begin
        loRes = (isSignedOp(opReg) && (negA ^ negB)) ? -q : q;
        hiRes = (isSignedOp(opReg) && negA) ? -rem : rem;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= ST_IDLE;
      opReg    <= OP_MULT;
      negA     <= 1'b0;
      negB     <= 1'b0;
      divZero  <= 1'b0;
      origA    <= '0;
      opnd     <= '0;
      rem      <= '0;
      q        <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      cnt      <= '0;
      oDone    <= 1'b0;
      oDivZero <= 1'b0;
    end else begin
      oDone    <= 1'b0;
      oDivZero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            opReg   <= iOp;
            negA    <= isSignedOp(iOp) & iA[WIDTH-1];
            negB    <= isSignedOp(iOp) & iB[WIDTH-1];
            origA   <= iA;
            divZero <= isDivOp(iOp) && (iB == '0);
            rem     <= '0;
            q       <= isDivOp(iOp) ? magA : magB;
            opnd    <= isDivOp(iOp) ? magB : magA;
            cnt     <= '0;
            state   <= ST_CALC;
          end else begin
            if (iMthi) hiReg <= iWrData;
            if (iMtlo) loReg <= iWrData;
          end
        end
        ST_CALC: begin
          if (iCancel) begin
            state <= ST_IDLE;
          end else begin
            rem <= remNext;
            q   <= qNext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!iCancel) begin
            hiReg    <= hiRes;
            loReg    <= loRes;
            oDone    <= 1'b1;
            oDivZero <= divZero;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oBusy = (state != ST_IDLE);
  assign oHi   = hiReg;
  assign oLo   = loReg;

endmodule
